// File: rtl/dram_refresh_arbiter_if.sv
// DRAM ownership handshake and refresh status between the RAS/CAS sequencer and the refresh arbiter.
interface dram_refresh_arbiter_if #(
  parameter int unsigned DEBT_W = 3
);
  logic              CPU_REQ;
  logic              CPU_GNT;
  logic              RFSH_RAS_N;
  logic              RFSH_CAS_N;
  logic              RFSH_BUSY;
  logic [DEBT_W-1:0] RFSH_DEBT;
  logic              OVERRUN;

  modport master (
    output CPU_REQ,
    input  CPU_GNT, RFSH_RAS_N, RFSH_CAS_N, RFSH_BUSY, RFSH_DEBT, OVERRUN
  );

  modport slave (
    input  CPU_REQ,
    output CPU_GNT, RFSH_RAS_N, RFSH_CAS_N, RFSH_BUSY, RFSH_DEBT, OVERRUN
  );
endinterface

// File: rtl/dram_refresh_arbiter.sv
// CBR refresh scheduler for the fast-RAM bank; hides refresh in bus-idle gaps and arbitrates
// DRAM ownership between CPU cycles and refresh.
module dram_refresh_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 220,
  parameter int unsigned MAX_DEBT         = 4,
  parameter int unsigned DEBT_W           = 3,
  parameter int unsigned RAS_CLKS         = 2,
  parameter int unsigned PRECHARGE_CLKS   = 2
) (
  input logic                   CLKCPU,
  input logic                   RESET,
  dram_refresh_arbiter_if.slave bus
);

  localparam int unsigned TMR_W   = $clog2(REFRESH_INTERVAL);
  localparam int unsigned CNT_MAX = (RAS_CLKS > PRECHARGE_CLKS) ? RAS_CLKS : PRECHARGE_CLKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU,
    CBR_CAS,
    CBR_RAS,
    CBR_PRE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [TMR_W-1:0]  timer;
  logic [DEBT_W-1:0] debt;
  logic              tick, dec, debt_full, overrun;
  logic              gnt_q, busy_q, cas_n_q, ras_n_q;
  logic              gnt_nxt, busy_nxt, cas_n_nxt, ras_n_nxt;

  assign tick      = (timer == TMR_W'(REFRESH_INTERVAL - 1));
  assign debt_full = (debt == DEBT_W'(MAX_DEBT));

  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // A tick coinciding with the CBR_PRE entry cancels out; a tick at full debt is lost and flagged.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      debt    <= '0;
      overrun <= 1'b0;
    end else if (tick && !dec) begin
      if (debt_full) begin
        overrun <= 1'b1;
      end else begin
        debt <= debt + 1'b1;
      end
    end else if (dec && !tick) begin
      debt <= debt - 1'b1;
    end
  end

  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      cas_n_q <= 1'b1;
      ras_n_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt_q   <= gnt_nxt;
      busy_q  <= busy_nxt;
      cas_n_q <= cas_n_nxt;
      ras_n_q <= ras_n_nxt;
    end
  end

  // Outputs are decoded from the next state so every strobe comes straight off a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dec       = 1'b0;
    unique case (state)
      IDLE: begin
        if (debt_full) begin
          state_nxt = CBR_CAS;
        end else if (bus.CPU_REQ) begin
          state_nxt = CPU;
        end else if (debt != '0) begin
          state_nxt = CBR_CAS;
        end
      end
      CPU: begin
        if (!bus.CPU_REQ) begin
          state_nxt = IDLE;
        end
      end
      CBR_CAS: begin
        state_nxt = CBR_RAS;
        cnt_nxt   = '0;
      end
      CBR_RAS: begin
        if (cnt == CNT_W'(RAS_CLKS - 1)) begin
          state_nxt = CBR_PRE;
          cnt_nxt   = '0;
          dec       = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CBR_PRE: begin
        if (cnt == CNT_W'(PRECHARGE_CLKS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    gnt_nxt   = (state_nxt == CPU);
    busy_nxt  = (state_nxt == CBR_CAS) || (state_nxt == CBR_RAS) || (state_nxt == CBR_PRE);
    cas_n_nxt = !((state_nxt == CBR_CAS) || (state_nxt == CBR_RAS));
    ras_n_nxt = (state_nxt != CBR_RAS);
  end

  assign bus.CPU_GNT    = gnt_q;
  assign bus.RFSH_BUSY  = busy_q;
  assign bus.RFSH_CAS_N = cas_n_q;
  assign bus.RFSH_RAS_N = ras_n_q;
  assign bus.RFSH_DEBT  = debt;
  assign bus.OVERRUN    = overrun;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Bench for dram_refresh_arbiter: directed scenarios plus random CPU traffic against a
// cycle-numbered reference model of refresh timing and ownership.
module tb_dram_refresh_arbiter;

  localparam int RI    = 220;
  localparam int MAXD  = 4;
  localparam int RASC  = 2;
  localparam int PREC  = 2;
  localparam int TOTAL = 1 + RASC + PREC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dram_refresh_arbiter_if #(.DEBT_W(3)) bus ();

  dram_refresh_arbiter #(
    .REFRESH_INTERVAL(RI),
    .MAX_DEBT(MAXD),
    .DEBT_W(3),
    .RAS_CLKS(RASC),
    .PRECHARGE_CLKS(PREC)
  ) dut (
    .CLKCPU(clk),
    .RESET(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference model: n = rising edges since reset release, s = edge at which the current
  // refresh began. Strobe/busy windows are offsets from s.
  int n = 0, s = -1000, m_debt = 0, ticks = 0;
  bit m_gnt = 0, m_ovr = 0;
  bit m_tick, m_dec, m_idle;
  int old_debt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; s = -1000; m_debt = 0; ticks = 0; m_gnt = 0; m_ovr = 0;
    end else begin
      n++;
      m_tick   = (n % RI) == 0;
      m_dec    = (n == s + 1 + RASC);
      m_idle   = !m_gnt && !((n - 1 - s) >= 0 && (n - 1 - s) < TOTAL);
      old_debt = m_debt;
      if (m_tick) ticks++;
      if (m_tick && !m_dec) begin
        if (m_debt == MAXD) m_ovr = 1; else m_debt++;
      end else if (m_dec && !m_tick) begin
        m_debt--;
      end
      if (m_gnt) begin
        if (!bus.CPU_REQ) m_gnt = 0;
      end else if (m_idle) begin
        if (old_debt == MAXD) s = n;
        else if (bus.CPU_REQ) m_gnt = 1;
        else if (old_debt > 0) s = n;
      end
    end
  end

  int  off;
  int  refreshes = 0;
  bit  prev_ras_n = 1, prev_cas_n = 1;

  always @(negedge clk) begin
    off = n - s;
    check("gnt",     bus.CPU_GNT,    m_gnt);
    check("busy",    bus.RFSH_BUSY,  (off >= 0 && off < TOTAL));
    check("cas_n",   bus.RFSH_CAS_N, !(off >= 0 && off <= RASC));
    check("ras_n",   bus.RFSH_RAS_N, !(off >= 1 && off <= RASC));
    check("debt",    bus.RFSH_DEBT,  m_debt);
    check("overrun", bus.OVERRUN,    m_ovr);
    check("gnt_busy_excl", bus.CPU_GNT & bus.RFSH_BUSY, 0);
    if (prev_ras_n && !bus.RFSH_RAS_N) check("cas_before_ras", prev_cas_n, 0);
    if (rst) begin
      refreshes  = 0;
      prev_ras_n = 1;
      prev_cas_n = 1;
    end else begin
      if (!prev_ras_n && bus.RFSH_RAS_N) refreshes++;
      prev_ras_n = bus.RFSH_RAS_N;
      prev_cas_n = bus.RFSH_CAS_N;
    end
  end

  // Release lands 2 time units after a falling edge, so the next rising edge is edge 1.
  task automatic do_reset(input logic req_at_release);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    bus.CPU_REQ = req_at_release;
    rst = 1'b0;
  endtask

  initial begin
    bus.CPU_REQ = 1'b0;
    @(negedge clk);
    check("rst_gnt",   bus.CPU_GNT, 0);
    check("rst_ras_n", bus.RFSH_RAS_N, 1);
    check("rst_cas_n", bus.RFSH_CAS_N, 1);
    check("rst_busy",  bus.RFSH_BUSY, 0);
    check("rst_ovr",   bus.OVERRUN, 0);
    @(negedge clk); #2;
    rst = 1'b0;

    // Idle refresh after first tick
    cyc(219); check("t1_debt_219", bus.RFSH_DEBT, 0);
    cyc(1);   check("t1_debt_220", bus.RFSH_DEBT, 1);
              check("t1_busy_220", bus.RFSH_BUSY, 0);
    cyc(1);   check("t1_cas_221",  bus.RFSH_CAS_N, 0);
              check("t1_ras_221",  bus.RFSH_RAS_N, 1);
    cyc(1);   check("t1_ras_222",  bus.RFSH_RAS_N, 0);
    cyc(2);   check("t1_debt_224", bus.RFSH_DEBT, 0);
              check("t1_cas_224",  bus.RFSH_CAS_N, 1);
              check("t1_busy_224", bus.RFSH_BUSY, 1);
    cyc(2);   check("t1_busy_226", bus.RFSH_BUSY, 0);

    // CPU request and pending debt together in IDLE
    cyc(214); check("t2_debt_440", bus.RFSH_DEBT, 1);
    bus.CPU_REQ = 1'b1;
    cyc(1);   check("t2_gnt_441",  bus.CPU_GNT, 1);
    cyc(4);   check("t2_cas_445",  bus.RFSH_CAS_N, 1);
    bus.CPU_REQ = 1'b0;
    cyc(1);   check("t2_gnt_446",  bus.CPU_GNT, 0);
    cyc(1);   check("t2_busy_447", bus.RFSH_BUSY, 1);
    cyc(5);   check("t2_debt_452", bus.RFSH_DEBT, 0);

    // CPU hog: debt saturates, overrun, then urgent refresh beats the CPU
    do_reset(1'b1);
    cyc(879); check("t3_debt_879", bus.RFSH_DEBT, 3);
    cyc(1);   check("t3_debt_880", bus.RFSH_DEBT, 4);
    cyc(219); check("t3_ovr_1099", bus.OVERRUN, 0);
    cyc(1);   check("t3_ovr_1100", bus.OVERRUN, 1);
    cyc(100); check("t3_gnt_1200", bus.CPU_GNT, 1);
    bus.CPU_REQ = 1'b0;
    cyc(1);   check("t3_gnt_1201", bus.CPU_GNT, 0);
    bus.CPU_REQ = 1'b1;
    cyc(1);   check("t3_busy_1202", bus.RFSH_BUSY, 1);
              check("t3_gnt_1202",  bus.CPU_GNT, 0);
    cyc(3);   check("t3_debt_1205", bus.RFSH_DEBT, 3);
    cyc(2);   check("t3_gnt_1207",  bus.CPU_GNT, 0);
    cyc(1);   check("t3_gnt_1208",  bus.CPU_GNT, 1);

    // Tick on the same edge as CBR_PRE entry
    do_reset(1'b1);
    cyc(655);
    bus.CPU_REQ = 1'b0;
    cyc(2);   check("t4_debt_657", bus.RFSH_DEBT, 2);
    cyc(3);   check("t4_debt_660", bus.RFSH_DEBT, 2);
              check("t4_ovr_660",  bus.OVERRUN, 0);
    cyc(10);  check("t4_ras_670",  bus.RFSH_RAS_N, 0);

    // Asynchronous reset in the middle of CBR_RAS
    #2 rst = 1'b1;
    #1;
    check("t5_ras_async",  bus.RFSH_RAS_N, 1);
    check("t5_cas_async",  bus.RFSH_CAS_N, 1);
    check("t5_debt_async", bus.RFSH_DEBT, 0);
    check("t5_ovr_async",  bus.OVERRUN, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    cyc(219); check("t5_debt_219", bus.RFSH_DEBT, 0);
    cyc(1);   check("t5_debt_220", bus.RFSH_DEBT, 1);

    // Random CPU traffic
    for (int i = 0; i < 20000; i++) begin
      if (bus.CPU_REQ) bus.CPU_REQ = ($urandom_range(7) != 0);
      else             bus.CPU_REQ = ($urandom_range(3) == 0);
      cyc(1);
    end
    bus.CPU_REQ = 1'b0;
    cyc(20);
    check("t6_ovr", bus.OVERRUN, 0);
    check("t6_ticks_accounted", ticks, refreshes + int'(bus.RFSH_DEBT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
